// File: rtl/elm_mult_pipe_pkg.sv
// Shared helpers for the Mitchell log-domain multiplier: width arithmetic and default sizes.
package elm_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Width of k1+k2: two positions up to W-1 each.
  function automatic int k_width(input int w);
    return clog2(w) + 1;
  endfunction

  localparam int W_DEFAULT      = 16;
  localparam int FRAC_W_DEFAULT = 4;
  localparam int TAG_W_DEFAULT  = 4;
  localparam int K_W_DEFAULT    = k_width(W_DEFAULT);

endpackage

// File: rtl/elm_mult_pipe_if.sv
// Operand/result handshake bundle of the approximate multiplier.
interface elm_mult_pipe_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     x;
  logic [W-1:0]     y;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [2*W-1:0]   p_out;

  modport slave (
    input  in_valid, in_signed, in_tag, x, y, out_ready,
    output in_ready, out_valid, out_tag, p_out
  );

  modport master (
    output in_valid, in_signed, in_tag, x, y, out_ready,
    input  in_ready, out_valid, out_tag, p_out
  );
endinterface

// File: rtl/elm_lod.sv
// Combinational leading-one detector: position of the highest set bit and a non-zero flag.
module elm_lod
  import elm_pkg::*;
#(
  parameter  int W     = 16,
  localparam int POS_W = clog2(W)
) (
  input  logic [W-1:0]     i_vec,
  output logic [POS_W-1:0] o_pos,
  output logic             o_valid
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    o_pos   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_pos   = POS_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elm_mult_pipe.sv
// Three-stage Mitchell approximate multiplier: sign/LOD, mantissa/exponent sum, antilog + sign.
module elm_mult_pipe
  import elm_pkg::*;
#(
  parameter int W      = 16,
  parameter int FRAC_W = 4,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  elm_mult_pipe_if.slave bus
);

  localparam int POS_W = clog2(W);
  localparam int K_W   = k_width(W);
  localparam int TMP_W = 2 * W + FRAC_W;

  // Payload widths follow the module parameters, so the struct lives here.
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [K_W-1:0]    k;
    logic [FRAC_W-1:0] m1;
    logic [FRAC_W-1:0] m2;
    logic [TAG_W-1:0]  tag;
  } payload_t;

  logic w_en;

  logic [W-1:0]     w_op    [2];
  logic             w_neg   [2];
  logic [W-1:0]     w_abs   [2];
  logic [POS_W-1:0] w_k     [2];
  logic             w_nz    [2];
  logic [POS_W-1:0] w_lsh   [2];
  logic [W-1:0]     w_align [2];
  logic [FRAC_W-1:0] w_m    [2];

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_zero;
  logic [TAG_W-1:0] r_s1_tag;
  logic [W-1:0]     r_s1_abs [2];
  logic [POS_W-1:0] r_s1_k   [2];

  payload_t w_s2_next;
  payload_t r_s2;
  logic     r_s2_valid;

  logic [FRAC_W:0]  w_msum;
  logic             w_ovf;
  logic [FRAC_W:0]  w_base;
  logic [K_W-1:0]   w_shamt;
  logic [TMP_W-1:0] w_scaled;
  logic [2*W-1:0]   w_mag;
  logic [2*W-1:0]   w_prod;

  logic             r_out_valid;
  logic [2*W-1:0]   r_p_out;
  logic [TAG_W-1:0] r_out_tag;

  logic w_unused_bits;

  // All stages advance together whenever the output register can move.
  assign w_en          = ~r_out_valid | bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.p_out     = r_p_out;
  assign bus.out_tag   = r_out_tag;

  assign w_op[0] = bus.x;
  assign w_op[1] = bus.y;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign w_neg[gi] = bus.in_signed & w_op[gi][W-1];
    // Negating -2^(W-1) wraps to 2^(W-1), which is exactly the wanted magnitude.
    assign w_abs[gi] = w_neg[gi] ? (~w_op[gi] + W'(1)) : w_op[gi];

    elm_lod #(.W(W)) u_lod (
      .i_vec   (w_abs[gi]),
      .o_pos   (w_k[gi]),
      .o_valid (w_nz[gi])
    );

    // Left-align the leading one at bit W-1; the mantissa is the field just below it.
    assign w_lsh[gi]   = POS_W'(W - 1) - r_s1_k[gi];
    assign w_align[gi] = r_s1_abs[gi] << w_lsh[gi];
    assign w_m[gi]     = w_align[gi][W-2 -: FRAC_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_tag   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_s1_abs[i] <= '0;
        r_s1_k[i]   <= '0;
      end
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_sign <= w_neg[0] ^ w_neg[1];
        r_s1_zero <= ~(w_nz[0] & w_nz[1]);
        r_s1_tag  <= bus.in_tag;
        for (int i = 0; i < 2; i++) begin
          r_s1_abs[i] <= w_abs[i];
          r_s1_k[i]   <= w_k[i];
        end
      end
    end
  end

  always_comb begin
    w_s2_next      = '0;
    w_s2_next.sign = r_s1_sign;
    w_s2_next.zero = r_s1_zero;
    w_s2_next.k    = K_W'(r_s1_k[0]) + K_W'(r_s1_k[1]);
    w_s2_next.m1   = w_m[0];
    w_s2_next.m2   = w_m[1];
    w_s2_next.tag  = r_s1_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2 <= w_s2_next;
      end
    end
  end

  // Mantissa carry: 1+m1+m2 >= 2 becomes m1+m2 at one extra power of two.
  assign w_msum   = {1'b0, r_s2.m1} + {1'b0, r_s2.m2};
  assign w_ovf    = w_msum[FRAC_W];
  assign w_base   = w_ovf ? w_msum : {1'b1, w_msum[FRAC_W-1:0]};
  assign w_shamt  = r_s2.k + K_W'(w_ovf);
  assign w_scaled = TMP_W'(w_base) << w_shamt;
  assign w_mag    = r_s2.zero ? '0 : w_scaled[FRAC_W +: 2*W];
  assign w_prod   = r_s2.sign ? -w_mag : w_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_p_out     <= '0;
      r_out_tag   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_p_out   <= w_prod;
        r_out_tag <= r_s2.tag;
      end
    end
  end

  // Leading-one bits and truncated fraction bits are intentionally dropped.
  assign w_unused_bits = ^{w_align[0], w_align[1], w_scaled};

endmodule

// File: tb/tb_elm_mult_pipe.sv
// Directed bench for elm_mult_pipe (W=16, FRAC_W=4): values, latency, stall, reset, random backpressure.
module tb_elm_mult_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   rand_bp = 1'b0;

  logic [31:0] exp_p   [$];
  logic [3:0]  exp_t   [$];
  int          exp_acc [$];
  bit          exp_lat [$];
  logic [31:0] obs_p   [$];
  logic [3:0]  obs_t   [$];
  int          obs_cyc [$];

  logic [31:0] b2b_exp [8] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32};

  elm_mult_pipe_if #(.W(16), .TAG_W(4)) bus ();

  elm_mult_pipe #(.W(16), .FRAC_W(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every completed output transfer, sampled well away from the edge.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      obs_p.push_back(bus.p_out);
      obs_t.push_back(bus.out_tag);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: floor-log2 exponent, fraction by subtraction, then the antilog formula.
  function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint ua, ub, ma, mb, msum, mag;
    int ka, kb, k;
    ua = (s && a[15]) ? (longint'(65536) - longint'(a)) : longint'(a);
    ub = (s && b[15]) ? (longint'(65536) - longint'(b)) : longint'(b);
    if (ua == 0 || ub == 0) return 32'd0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 17; i++) begin
      if (ua >= (longint'(1) << i)) ka = i;
      if (ub >= (longint'(1) << i)) kb = i;
    end
    ma = (ka >= 4) ? ((ua - (longint'(1) << ka)) >> (ka - 4)) : ((ua - (longint'(1) << ka)) << (4 - ka));
    mb = (kb >= 4) ? ((ub - (longint'(1) << kb)) >> (kb - 4)) : ((ub - (longint'(1) << kb)) << (4 - kb));
    msum = ma + mb;
    k = ka + kb;
    if (msum < 16) mag = ((16 + msum) << k) >> 4;
    else           mag = (msum << (k + 1)) >> 4;
    if (s && (a[15] ^ b[15])) mag = -mag;
    return mag[31:0];
  endfunction

  task automatic send(input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] t, input logic [31:0] e, input bit lat);
    bit ok;
    ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.x         = a;
    bus.y         = b;
    bus.in_tag    = t;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rand_bp) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
      end
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_wait", 64'(ok), 64'd1);
    exp_p.push_back(e);
    exp_t.push_back(t);
    exp_acc.push_back(cyc);
    exp_lat.push_back(lat);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input bit consec);
    int guard;
    int prev;
    int idx;
    logic [31:0] ep, op;
    logic [3:0]  et, ot;
    int          ea, oc;
    bit          el;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rand_bp       = 1'b0;
    guard = 0;
    while (obs_p.size() < exp_p.size() && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_count"}, 64'(obs_p.size()), 64'(exp_p.size()));
    prev = -1;
    idx  = 0;
    while (exp_p.size() > 0 && obs_p.size() > 0) begin
      ep = exp_p.pop_front();
      et = exp_t.pop_front();
      ea = exp_acc.pop_front();
      el = exp_lat.pop_front();
      op = obs_p.pop_front();
      ot = obs_t.pop_front();
      oc = obs_cyc.pop_front();
      $display("[TB] %s txn %0d tag=%0d p_out=%08h want=%08h cyc=%0d", name, idx, ot, op, ep, oc);
      check($sformatf("%s_p[%0d]", name, idx), 64'(op), 64'(ep));
      check($sformatf("%s_tag[%0d]", name, idx), 64'(ot), 64'(et));
      if (el) check($sformatf("%s_lat[%0d]", name, idx), 64'(oc - ea), 64'd3);
      if (consec && prev >= 0) check($sformatf("%s_gap[%0d]", name, idx), 64'(oc - prev), 64'd1);
      prev = oc;
      idx++;
    end
    exp_p.delete();
    exp_t.delete();
    exp_acc.delete();
    exp_lat.delete();
    obs_p.delete();
    obs_t.delete();
    obs_cyc.delete();
  endtask

  initial begin
    logic        rs;
    logic [15:0] ra, rb;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_tag    = '0;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_p_out", 64'(bus.p_out), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned products, including the largest operands
    send(1'b0, 16'd3,     16'd3,     4'd0, 32'd8,        1'b1);
    send(1'b0, 16'd16,    16'd16,    4'd1, 32'd256,      1'b1);
    send(1'b0, 16'd65535, 16'd1,     4'd2, 32'd63488,    1'b1);
    send(1'b0, 16'hFFFF,  16'hFFFF,  4'd3, 32'hF0000000, 1'b1);
    send(1'b0, 16'hFFFD,  16'd3,     4'd4, 32'h0002E000, 1'b1);
    drain("unsigned", 1'b0);

    // Signed products, including the most negative operand
    send(1'b1, 16'hFFFD,  16'd3,     4'd5, 32'hFFFFFFF8, 1'b1);
    send(1'b1, 16'h8000,  16'd1,     4'd6, 32'hFFFF8000, 1'b1);
    send(1'b1, 16'h8000,  16'h8000,  4'd7, 32'h40000000, 1'b1);
    send(1'b1, 16'hFFFF,  16'hFFFF,  4'd8, 32'h00000001, 1'b1);
    send(1'b1, 16'hFFFF,  16'd1,     4'd9, 32'hFFFFFFFF, 1'b1);
    drain("signed", 1'b0);

    // Zero operands in both modes
    send(1'b0, 16'd0,     16'd12345, 4'd10, 32'd0, 1'b1);
    send(1'b1, 16'd0,     16'hFFFB,  4'd11, 32'd0, 1'b1);
    send(1'b1, 16'hFFFB,  16'd0,     4'd12, 32'd0, 1'b1);
    drain("zero", 1'b0);

    // Back-to-back beats at full throughput
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 16'(i + 1), 16'd4, 4'(i), b2b_exp[i], 1'b1);
    end
    drain("b2b", 1'b1);

    // Pipeline full under backpressure
    bus.out_ready = 1'b0;
    send(1'b0, 16'd2,  16'd2,  4'd8,  32'd4,  1'b0);
    send(1'b0, 16'd5,  16'd7,  4'd9,  32'd32, 1'b0);
    send(1'b0, 16'd10, 16'd10, 4'd10, 32'd96, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready[%0d]", i), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall_valid[%0d]", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("stall_p_out[%0d]", i), 64'(bus.p_out), 64'd4);
      check($sformatf("stall_tag[%0d]", i), 64'(bus.out_tag), 64'd8);
    end
    @(posedge clk);
    #1;
    drain("stall", 1'b0);

    // Reset with three operations in flight
    bus.out_ready = 1'b0;
    send(1'b0, 16'd3, 16'd3, 4'd1, 32'd0, 1'b0);
    send(1'b0, 16'd4, 16'd4, 4'd2, 32'd0, 1'b0);
    send(1'b0, 16'd5, 16'd5, 4'd3, 32'd0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_p_out", 64'(bus.p_out), 64'd0);
    check("mid_rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_p.delete();
    exp_t.delete();
    exp_acc.delete();
    exp_lat.delete();
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_no_stale", 64'(obs_p.size()), 64'd0);
    send(1'b0, 16'd3, 16'd3, 4'd4, 32'd8, 1'b1);
    drain("post_reset", 1'b0);

    // Mixed-mode traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      send(rs, ra, rb, 4'(i), ref_mul(rs, ra, rb), 1'b0);
    end
    drain("random", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
